// File: rtl/serial_loader.sv
// ============================================================================
// Module   : serial_loader
// Purpose  : Bit-serial, MSB-first front end that assembles WIDTH-bit words
//            for a downstream register; optional even parity via the
//            SERIAL_LOADER_PARITY_EN macro.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_loader #(
    parameter int WIDTH   = 6,
    parameter int TIMEOUT = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    output logic [WIDTH-1:0]             out,
    output logic                         enable,
    output logic                         error,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int                 c_cw        = $clog2(WIDTH + 1);
    localparam int                 c_sw        = (WIDTH > 1) ? WIDTH - 1 : 1;
    localparam logic [c_cw-1:0]    c_width_cnt = c_cw'(WIDTH);
    localparam logic [7:0]         c_timeout   = 8'(TIMEOUT);

`ifdef SERIAL_LOADER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
    } state_t;
`endif

    state_t             r_state,  w_state_next;
    logic [c_sw-1:0]    r_shift,  w_shift_next;
    logic [c_cw-1:0]    r_count,  w_count_next;
    logic [7:0]         r_idle,   w_idle_next;
    logic [WIDTH-1:0]   r_out,    w_out_next;
    logic               r_enable, w_enable_next;
    logic               r_error,  w_error_next;

    logic [WIDTH-1:0]   w_word;
    logic [c_sw-1:0]    w_shift_keep;
    logic [c_cw-1:0]    w_count_inc;
    logic [7:0]         w_idle_inc;

    assign w_count_inc = r_count + 1'b1;
    assign w_idle_inc  = r_idle + 8'd1;

    // Only the first WIDTH-1 bits need storage; the last bit arrives live.
    generate
        if (WIDTH > 1) begin : g_shift_wide
            assign w_word       = {r_shift, bit_in};
            assign w_shift_keep = w_word[c_sw-1:0];
        end else begin : g_shift_one
            assign w_word       = bit_in;
            assign w_shift_keep = r_shift;
        end
    endgenerate

`ifdef SERIAL_LOADER_PARITY_EN
    logic [WIDTH-1:0]   r_hold, w_hold_next;
    logic               w_parity_ok;

    assign w_parity_ok = ~(^r_hold ^ bit_in);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_count  <= '0;
            r_idle   <= '0;
            r_out    <= '0;
            r_enable <= 1'b0;
            r_error  <= 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
            r_hold   <= '0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_count  <= w_count_next;
            r_idle   <= w_idle_next;
            r_out    <= w_out_next;
            r_enable <= w_enable_next;
            r_error  <= w_error_next;
`ifdef SERIAL_LOADER_PARITY_EN
            r_hold   <= w_hold_next;
`endif
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_count_next  = r_count;
        w_idle_next   = r_idle;
        w_out_next    = r_out;
        w_enable_next = 1'b0;
        w_error_next  = 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
        w_hold_next   = r_hold;
`endif
        case (r_state)
            // IDLE has count 0, so the same accept path serves both states.
            S_IDLE, S_SHIFT: begin
                if (bit_valid) begin
                    w_shift_next = w_shift_keep;
                    w_idle_next  = '0;
                    if (w_count_inc == c_width_cnt) begin
`ifdef SERIAL_LOADER_PARITY_EN
                        w_hold_next   = w_word;
                        w_count_next  = c_width_cnt;
                        w_state_next  = S_PARITY;
`else
                        w_out_next    = w_word;
                        w_enable_next = 1'b1;
                        w_count_next  = '0;
                        w_state_next  = S_IDLE;
`endif
                    end else begin
                        w_count_next = w_count_inc;
                        w_state_next = S_SHIFT;
                    end
                end else if (r_state == S_SHIFT) begin
                    if (w_idle_inc == c_timeout) begin
                        w_error_next = 1'b1;
                        w_count_next = '0;
                        w_idle_next  = '0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_idle_next = w_idle_inc;
                    end
                end
            end
`ifdef SERIAL_LOADER_PARITY_EN
            S_PARITY: begin
                if (bit_valid) begin
                    w_idle_next  = '0;
                    w_count_next = '0;
                    w_state_next = S_IDLE;
                    if (w_parity_ok) begin
                        w_out_next    = r_hold;
                        w_enable_next = 1'b1;
                    end else begin
                        w_error_next = 1'b1;
                    end
                end else if (w_idle_inc == c_timeout) begin
                    w_error_next = 1'b1;
                    w_count_next = '0;
                    w_idle_next  = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_idle_next = w_idle_inc;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
                w_count_next = '0;
                w_idle_next  = '0;
            end
        endcase
    end

    assign out    = r_out;
    assign enable = r_enable;
    assign error  = r_error;
    assign busy   = (r_state != S_IDLE);
    assign count  = r_count;

endmodule

`default_nettype wire
